// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: a scoreboard of in-flight writers from EX to WB drives stall, flush and bypass selects.
// Define PIPE_HAZARD_FWD_EN for bypass forwarding with load-use stalls; leave it undefined for interlock-only mode.
module pipe_hazard_ctrl #(
  parameter int BITS     = 32,
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            br_taken,
  output logic            stall,
  output logic            flush,
  output logic [SW-1:0]   fwd_a_sel,
  output logic [SW-1:0]   fwd_b_sel,
  output logic [BITS-1:0] stall_cnt
);

  logic [DEPTH-1:0] v_r;
  logic [DEPTH-1:0] ld_r;
  logic [AW-1:0]    rd_r [DEPTH];
  logic [DEPTH-1:0] m_a_s;
  logic [DEPTH-1:0] m_b_s;
  logic [SW-1:0]    fa_s;
  logic [SW-1:0]    fb_s;
  logic             hazard_s;
  logic             stall_s;
  logic             flush_s;
  logic             new_v_s;
  logic [BITS-1:0]  stall_cnt_r;
  logic             unused_s;

  // Per-entry operand match against live writers (rd of x0 never matches)
  always_comb begin
    m_a_s = '0;
    m_b_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_a_s[i] = v_r[i] && (rd_r[i] != '0) && id_rs1_used && (rd_r[i] == id_rs1);
      m_b_s[i] = v_r[i] && (rd_r[i] != '0) && id_rs2_used && (rd_r[i] == id_rs2);
    end
  end

  // Forwarding select and hazard detection
  always_comb begin
    fa_s     = '0;
    fb_s     = '0;
    hazard_s = 1'b0;
`ifdef PIPE_HAZARD_FWD_EN
    // Walk oldest to youngest so the youngest matching entry overrides
    for (int i = DEPTH - 1; i >= 0; i--) begin
      fa_s = m_a_s[i] ? SW'(i + 1) : fa_s;
      fb_s = m_b_s[i] ? SW'(i + 1) : fb_s;
    end
    for (int i = 0; i < LOAD_LAT; i++) begin
      hazard_s = hazard_s | ((m_a_s[i] | m_b_s[i]) & ld_r[i]);
    end
`else
    // No bypass: any in-flight writer, WB included, must drain first
    hazard_s = |(m_a_s | m_b_s);
`endif
  end

  assign flush_s   = !rst && br_taken;
  assign stall_s   = !rst && id_valid && !br_taken && hazard_s;
  assign new_v_s   = id_valid && id_we && (id_rd != '0) && !stall_s && !flush_s;
  assign stall     = stall_s;
  assign flush     = flush_s;
  assign fwd_a_sel = (!rst && id_valid) ? fa_s : '0;
  assign fwd_b_sel = (!rst && id_valid) ? fb_s : '0;
  assign stall_cnt = stall_cnt_r;
  assign unused_s  = ^ld_r;

  // Scoreboard advance and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      v_r         <= '0;
      ld_r        <= '0;
      stall_cnt_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i] <= '0;
      end
    end else begin
      v_r     <= {v_r[DEPTH-2:0], new_v_s};
      ld_r    <= {ld_r[DEPTH-2:0], id_is_load};
      rd_r[0] <= id_rd;
      for (int i = 1; i < DEPTH; i++) begin
        rd_r[i] <= rd_r[i-1];
      end
      if (stall_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + BITS'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow PIPE_HAZARD_FWD_EN when defined, interlock-only otherwise.
module tb_pipe_hazard_ctrl;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int BITS  = 32;
  localparam int SW    = $clog2(DEPTH + 1);
`ifdef PIPE_HAZARD_FWD_EN
  localparam int CNT_A = 1'b0 ? 1 : 0;
  localparam int CNT_L = 1;
  localparam int CNT_Y = 1;
  localparam int FA_R2 = 1;
`else
  localparam int CNT_A = 3;
  localparam int CNT_L = 6;
  localparam int CNT_Y = 9;
  localparam int FA_R2 = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  logic id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, br_taken;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic stall, flush, stall2, flush2;
  logic [SW-1:0] fwd_a_sel, fwd_b_sel, fa2, fb2;
  logic [BITS-1:0] stall_cnt;
  logic [2:0] cnt2;

  pipe_hazard_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .AW(AW), .LOAD_LAT(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .br_taken(br_taken), .stall(stall), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
  );

  // Narrow counter instance with a self-sustaining hazard, used for saturation
  pipe_hazard_ctrl #(.BITS(3), .DEPTH(DEPTH), .AW(AW), .LOAD_LAT(1)) dut_sat (
    .clk(clk), .rst(rst2), .id_valid(1'b1), .id_rs1(5'd5), .id_rs2(5'd0),
    .id_rs1_used(1'b1), .id_rs2_used(1'b0), .id_rd(5'd5), .id_we(1'b1),
    .id_is_load(1'b1), .br_taken(1'b0), .stall(stall2), .flush(flush2),
    .fwd_a_sel(fa2), .fwd_b_sel(fb2), .stall_cnt(cnt2)
  );

  typedef struct {
    string tag;
    logic  st;
    logic  fl;
    int    fa;
    int    fb;
    bit    cf;
  } exp_t;

  exp_t q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic v, input logic [AW-1:0] r1, input logic u1,
                      input logic [AW-1:0] r2, input logic u2, input logic [AW-1:0] rd,
                      input logic we, input logic ld, input logic br,
                      input logic est, input logic efl, input int efa, input int efb, input bit cf);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_we = we; id_is_load = ld; br_taken = br;
    q.push_back('{tag, est, efl, efa, efb, cf});
    @(negedge clk);
    e = q.pop_front();
    chk({e.tag, ".stall"}, 32'(stall), 32'(e.st));
    chk({e.tag, ".flush"}, 32'(flush), 32'(e.fl));
    if (e.cf) begin
      chk({e.tag, ".fwd_a"}, 32'(fwd_a_sel), e.fa);
      chk({e.tag, ".fwd_b"}, 32'(fwd_b_sel), e.fb);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step("idle", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_rd = '0; id_we = 1'b0; id_is_load = 1'b0; br_taken = 1'b0;

    // Outputs gated while in reset even with a branch and hazard-looking ID
    step("rst0", 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    step("rst1", 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    chk("rst_cnt", stall_cnt, 32'd0);
    rst = 1'b0;
    idle(3);

    // addi x5 ; add x6,x5,x5
    step("a1", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
`ifdef PIPE_HAZARD_FWD_EN
    step("a2", 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1);
`else
    for (int k = 0; k < 3; k++)
      step("a2s", 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    step("a2", 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
`endif
    idle(3);
    chk("cnt_a", stall_cnt, CNT_A);

    // lw x3 ; add x4,x3,x1
    step("l1", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
`ifdef PIPE_HAZARD_FWD_EN
    step("l2s", 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
    step("l2", 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1);
`else
    for (int k = 0; k < 3; k++)
      step("l2s", 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    step("l2", 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
`endif
    idle(3);
    chk("cnt_l", stall_cnt, CNT_L);

    // Three writers of x7 fill every entry, then a read of x7
    for (int k = 0; k < 3; k++)
      step("y_wr", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
`ifdef PIPE_HAZARD_FWD_EN
    step("y_rd", 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1);
`else
    for (int k = 0; k < 3; k++)
      step("y_rds", 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    step("y_rd", 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
`endif
    idle(3);
    chk("cnt_y", stall_cnt, CNT_Y);

    // Branch taken with a load-use hazard in ID; flushed x9 writer must become a bubble
    step("b1", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    step("b2", 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
    step("b3", 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    chk("cnt_b", stall_cnt, CNT_Y);
    idle(3);

    // Load into x0, then read x0 on both operands
    step("z1", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    step("z2", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    idle(3);

    // Reset in the middle of a stall
    step("r1", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    step("r2", 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FA_R2, 0, 1'b1);
    chk("cnt_r2", stall_cnt, CNT_Y);
    rst = 1'b1;
    step("r3", 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    chk("cnt_r3", stall_cnt, 32'd0);
    rst = 1'b0;
    step("r4", 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    chk("cnt_r4", stall_cnt, 32'd0);

    // Narrow counter saturates at all-ones, then reset clears it
    rst2 = 1'b0;
    repeat (40) @(negedge clk);
    chk("sat_cnt", 32'(cnt2), 32'd7);
    rst2 = 1'b1;
    @(negedge clk);
    chk("sat_rst_cnt", 32'(cnt2), 32'd0);
    chk("sat_rst_stall", 32'(stall2), 32'd0);
    chk("sat_rst_flush", 32'(flush2), 32'd0);
    chk("sat_rst_fwd", 32'({fa2, fb2}), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
It replaces the fixed-depth, stall-only hazard logic with a scoreboard of in-flight writers, one entry per stage from EX to WB.
Each cycle it issues stall, flush and per-operand forwarding selects to the ID/EX datapath, and it counts stall cycles.
The pipeline depth and load latency are parameters.

Parameters:
BITS, 32, datapath width; used only for the stall counter width
DEPTH, 3, tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WB); legal range 2..6
AW, 5, register address width
LOAD_LAT, 1, stages after EX before load data can be forwarded; legal range 1..DEPTH-1
SW, $clog2(DEPTH+1), forwarding select width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  AW  ID source register 1
id_rs2  in  AW  ID source register 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  AW  ID destination register
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a LOAD
br_taken  in  1  branch/jump in EX redirects the PC this cycle
stall  out  1  hold PC and IF/ID, inject bubble into EX
flush  out  1  squash IF/ID and the ID instruction
fwd_a_sel  out  SW  rs1 source: 0 = regfile, k = result of entry k-1
fwd_b_sel  out  SW  rs2 source, same encoding
stall_cnt  out  BITS  saturating count of stall cycles

Behaviour:
Scoreboard
- Each entry holds {v, rd, ld}.
- An entry is a writer iff v=1 and rd!=0.
- An instruction with id_we=0 or id_rd=0 is stored with v=0.

Advance (every rising edge, rst=0)
- entry[i] <= entry[i-1] for i = 1..DEPTH-1.
- entry[0] <= {id_valid & id_we & (id_rd!=0) & !stall & !flush, id_rd, id_is_load}.
- The oldest entry (WB) retires. Its register file write is not visible to a same-cycle read.

Match
- m_a[i] = writer(entry[i]) & id_rs1_used & (entry[i].rd == id_rs1). m_b[i] is the same for rs2.

Forwarding (combinational)
- fwd_a_sel = k+1, where k is the smallest i with m_a[i]=1.
- fwd_a_sel = 0 if no entry matches.
- Youngest match wins.
- fwd_b_sel is computed the same way from m_b.

Load-use stall (combinational)
- stall = id_valid & !br_taken & OR over i<LOAD_LAT of ((m_a[i] | m_b[i]) & entry[i].ld).
- The stall is re-evaluated every cycle. It clears when the load moves past entry LOAD_LAT-1. With default parameters this is exactly one bubble per load-use pair.

Flush
- flush = br_taken, combinational.
- flush forces stall=0. Flush takes priority, because the ID instruction is wrong-path.
- The branch itself in entry[0] advances normally.
- A flushed or stalled ID instruction enters entry[0] as a bubble.

Outputs during flush
- fwd selects are don't-care while flush=1.
- They are 0 whenever id_valid=0.

Counter
- stall_cnt increments on each edge where stall=1.
- It holds at all-ones.

Reset
- All entries cleared to v=0. stall_cnt=0.
- stall=0, flush=0 and fwd_*_sel=0 while rst=1. These outputs are gated by rst.
- Reset during a stall ends the stall on the next cycle.

Boundary rules
- rs1==rs2 with both matched: both selects are set identically.
- An rd of x0 is never forwarded and never stalls.
- DEPTH entries all matching: the youngest wins.

Optional Feature:
Macro PIPE_HAZARD_FWD_EN.
- Defined: forwarding and load-use stalls as above.
- Undefined (interlock-only mode, for the datapath without bypass muxes):
  - fwd_a_sel and fwd_b_sel are tied to 0.
  - stall = id_valid & !br_taken & OR over all i of (m_a[i] | m_b[i]).
  - This includes the WB entry, which covers the same-cycle write/read.
  - Load flag unused.

Test Plan:
1. `addi x5,x0,7` followed by `add x6,x5,x5` (FWD_EN) -> on the add's ID cycle fwd_a_sel=1, fwd_b_sel=1, stall=0.
2. `lw x3,0(x0)` followed by `add x4,x3,x1` -> stall=1 for exactly 1 cycle, then fwd_a_sel=2, fwd_b_sel=0; stall_cnt=1.
3. Writes to x7 from two back-to-back instructions, then a read of x7 -> fwd_a_sel=1 (youngest), not 2.
4. br_taken=1 in the same cycle a load-use hazard is present in ID -> flush=1, stall=0; the next cycle entry[0].v=0; stall_cnt unchanged.
5. Writer to x0, then a read of x0 -> fwd_a_sel=0, stall=0. Without FWD_EN, `addi x5` followed by a read of x5 -> stall=1 for DEPTH (3) cycles, fwd selects always 0.
6. Assert rst mid-stall with stall_cnt preset near 2^BITS-1 -> all outputs 0 the cycle after. A separate run of 2^BITS+ stalls with a small BITS override shows stall_cnt saturating at all-ones.
